// File: rtl/bcd_display_scan.sv
// bcd_display_scan: scans six BCD digits (HH:MM:SS) onto a multiplexed 7-segment display.
// Each frame shows one coherent snapshot of the digits. The display supports hour-tens blanking and alarm blink.
module bcd_display_scan #(
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_DIV    = 64,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       alarm,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // Segment codes indexed by digit value; codes 10-15 decode to blank
    localparam logic [15:0][6:0] LUT = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66,
                                        7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic [PW-1:0]     pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0][3:0]   sh_q, sh_d;
    logic [BW-1:0]     bc_q, bc_d;
    logic              ph_q, ph_d;
    logic              ft_q;
    logic [6:0]        seg_q, seg_d;
    logic [5:0]        an_q, an_d;
    logic              dp_q, dp_d;
    logic              tick, wrap, off;
    logic [3:0]        digit;

    always_comb begin
        tick  = pre_q == PW'(CLK_DIV - 1);
        wrap  = tick && idx_q == 3'd5;
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = tick ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
        sh_d  = wrap ? {2'b00, H_in1, H_in0, M_in1, M_in0, S_in1, S_in0} : sh_q;
        bc_d  = !alarm ? '0 : wrap ? (bc_q == BW'(BLINK_DIV - 1) ? '0 : bc_q + 1'b1) : bc_q;
        ph_d  = !alarm ? 1'b0 : (wrap && bc_q == BW'(BLINK_DIV - 1)) ? ~ph_q : ph_q;
        digit = sh_q[idx_q];
        off   = (alarm && ph_q) || (blank_lead && idx_q == 3'd5 && digit == 4'd0);
        seg_d = off ? 7'h00 : LUT[digit];
        an_d  = off ? 6'h00 : 6'(1) << idx_q;
        dp_d  = !off && (idx_q == 3'd2 || idx_q == 3'd4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            idx_q <= '0;
            sh_q  <= '0;
            bc_q  <= '0;
            ph_q  <= 1'b0;
            ft_q  <= 1'b0;
            seg_q <= {7{COMMON_ANODE}};
            an_q  <= {6{COMMON_ANODE}};
            dp_q  <= COMMON_ANODE;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            sh_q  <= sh_d;
            bc_q  <= bc_d;
            ph_q  <= ph_d;
            ft_q  <= wrap;
            seg_q <= seg_d ^ {7{COMMON_ANODE}};
            an_q  <= an_d ^ {6{COMMON_ANODE}};
            dp_q  <= dp_d ^ COMMON_ANODE;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;
endmodule
